prbs31_seq_ctrl: RTL
====================

PRBS31_SEQ_CTRL -- requirements
Module: prbs31_seq_ctrl

Interface
- REQ-001: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-002: rst  input  1  reset, synchronous, active-high.
- REQ-003: start  input  1  burst request; sampled only in IDLE.
- REQ-004: abort  input  1  terminates a burst in progress; sampled only in RUN.
- REQ-005: burst_len  input  8  number of bytes per burst, latched on accepted start; 0 means 256.
- REQ-006: check_in  input  8  looped-back byte for checking, MSB is the earliest bit.
- REQ-007: check_valid  input  1  check_in is qualified this cycle.
- REQ-008: data_out  output  8  generated PRBS-31 byte, MSB is the earliest bit.
- REQ-009: data_valid  output  1  data_out is qualified this cycle.
- REQ-010: busy  output  1  high in RUN and DONE.
- REQ-011: done  output  1  one-cycle pulse at normal burst completion.
- REQ-012: err_cnt  output  8  saturating bit-error count from the checker.
- REQ-013: synced  output  1  checker has received at least 31 bits since clear.

Function
- REQ-014: The generator SHALL be a 31-bit LFSR, polynomial x^31+x^28+1; each new bit = s[30]^s[27], shifted into s[0].
- REQ-015: In RUN the LFSR SHALL advance 8 bits per cycle; data_out[7] is the first new bit, data_out[0] the eighth.
- REQ-016: FSM states are IDLE, RUN, DONE; reset enters IDLE.
- REQ-017: IDLE to RUN when start=1. Same edge: LFSR loads 31'h7FFFFFFF, burst_len latches, err_cnt clears, the checker history and sync counter clear.
- REQ-018: The first data_valid SHALL occur in the cycle after the start cycle. data_valid stays high for exactly N consecutive cycles, with N = latched burst_len (256 if 0).
- REQ-019: RUN to DONE on the edge that completes the Nth byte. DONE lasts one cycle with done=1 and data_valid=0, then returns to IDLE.
- REQ-020: abort=1 in RUN SHALL move the FSM to IDLE on that edge. The byte presented in that cycle is the last one. No done pulse is produced, and err_cnt is retained.
- REQ-021: start SHALL be ignored in RUN and DONE. abort SHALL be ignored in IDLE and DONE. If start and abort are both high in IDLE, start wins.
- REQ-022: data_out SHALL hold its last value when data_valid=0. The byte counter SHALL not wrap within a burst.
- REQ-023: The checker SHALL be self-synchronising and independent of the FSM and of loop latency. It runs whenever check_valid=1, processing check_in MSB-first.
- REQ-024: For each received bit, expected = h[30]^h[27], where h holds the previous 31 received bits. The received bit, not the expected bit, is then shifted into h.
- REQ-025: A mismatch SHALL be counted only when at least 31 bits have been received since the last clear. synced asserts once the received-bit count reaches 31, and the counter saturates.
- REQ-026: err_cnt SHALL add the number of counted mismatches in the byte (0..8) each check_valid cycle, saturating at 255.
- REQ-027: A single flipped received bit, once synced, SHALL produce exactly 3 counted mismatches: the bit itself plus the 28- and 31-bit-later taps.

Reset
- REQ-028: On rst=1 at an edge, the block SHALL take these values regardless of other inputs: state=IDLE, LFSR=31'h7FFFFFFF, data_out=0, data_valid=0, busy=0, done=0, err_cnt=0, synced=0, checker history=0, byte counter=0.
- REQ-029: rst mid-burst SHALL abandon the burst with no done pulse. The first edge after rst deasserts may accept start.

Verification
- REQ-030: rst, then start with burst_len=4 -> data_valid high 4 cycles starting the cycle after start; data_out = 00,00,00,0E; done pulses once; busy drops after DONE.
- REQ-031: burst_len=0, loopback (check_in=data_out, check_valid=data_valid) -> 256 valid cycles; synced=1 after the 4th byte; err_cnt=0 at done.
- REQ-032: burst_len=16, loopback, flip check_in bit 5 of byte 8 -> err_cnt=3 at done.
- REQ-033: burst_len=10, abort asserted on the 3rd valid cycle -> exactly 3 valid bytes, no done, busy=0 the next cycle; start pulsed in RUN earlier -> ignored.
- REQ-034: check_valid held high with check_in=8'hFF after sync, held long enough -> err_cnt saturates at 255 and does not wrap; a following start -> err_cnt=0.
- REQ-035: rst asserted mid-burst with start held high -> all outputs return to their reset values; the burst restarts from seed only after rst deasserts.

Source files
------------

// File: rtl/prbs31_seq_ctrl.sv
// PRBS-31 burst generator with a free-running, self-synchronising loopback checker.
// The generator emits one byte per cycle for a latched burst length. The checker
// counts bit errors on any qualified byte stream, independent of the burst FSM.
module prbs31_seq_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] burst_len,
   input  logic [7:0] check_in,
   input  logic       check_valid,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       busy,
   output logic       done,
   output logic [7:0] err_cnt,
   output logic       synced
);

   localparam int unsigned LFSR_W = 31;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 9;
   localparam int unsigned SYNC_W = 5;
   localparam int unsigned NERR_W = 4;
   localparam int unsigned SUM_W  = BYTE_W + 1;
   localparam int unsigned STEP_W = LFSR_W + BYTE_W;
   localparam int unsigned CHK_W  = LFSR_W + SYNC_W + NERR_W;
   localparam int unsigned TAP_A  = 30;
   localparam int unsigned TAP_B  = 27;

   localparam logic [LFSR_W-1:0] SEED      = '1;
   localparam logic [SYNC_W-1:0] SYNC_BITS = SYNC_W'(31);
   localparam logic [CNT_W-1:0]  FULL_LEN  = CNT_W'(256);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [LFSR_W-1:0]  lfsr;        // generator state after the byte on data_out
   logic [CNT_W-1:0]   byte_cnt;    // bytes presented so far in this burst
   logic [CNT_W-1:0]   len_q;       // latched burst length, 1..256
   logic [LFSR_W-1:0]  hist;        // last 31 received bits, newest in bit 0
   logic [SYNC_W-1:0]  rx_cnt;      // received bits since clear, saturates at 31

   logic [STEP_W-1:0]  seed_step_c;
   logic [STEP_W-1:0]  run_step_c;
   logic [CNT_W-1:0]   len_c;
   logic               accept_c;
   logic [CHK_W-1:0]   chk_c;
   logic [LFSR_W-1:0]  hist_nxt_c;
   logic [SYNC_W-1:0]  rx_cnt_nxt_c;
   logic [NERR_W-1:0]  nerr_c;
   logic [SUM_W-1:0]   err_sum_c;
   logic [BYTE_W-1:0]  err_sat_c;

   // Advance the LFSR by 8 bits; returns {next_state, byte} with the first new bit in the MSB.
   function automatic logic [STEP_W-1:0] prbs_step8(input logic [LFSR_W-1:0] s_in);
      logic [LFSR_W-1:0] s;
      logic [BYTE_W-1:0] b;
      logic              nb;
      s = s_in;
      b = '0;
      for (int i = 0; i < int'(BYTE_W); i++) begin
         nb = s[TAP_A] ^ s[TAP_B];
         b  = {b[BYTE_W-2:0], nb};
         s  = {s[LFSR_W-2:0], nb};
      end
      return {s, b};
   endfunction

   // Check one byte MSB-first against the history; returns {hist, rx_cnt, mismatches}.
   function automatic logic [CHK_W-1:0] check_step8(input logic [LFSR_W-1:0] h_in,
                                                    input logic [SYNC_W-1:0] c_in,
                                                    input logic [BYTE_W-1:0] d_in);
      logic [LFSR_W-1:0] h;
      logic [SYNC_W-1:0] c;
      logic [BYTE_W-1:0] d;
      logic [NERR_W-1:0] n;
      logic              rb;
      h = h_in;
      c = c_in;
      d = d_in;
      n = '0;
      for (int i = 0; i < int'(BYTE_W); i++) begin
         rb = d[BYTE_W-1];
         d  = {d[BYTE_W-2:0], 1'b0};
         // Only count once a full 31-bit history of real received bits exists.
         if ((c == SYNC_BITS) && (rb != (h[TAP_A] ^ h[TAP_B]))) begin
            n = n + NERR_W'(1);
         end
         h = {h[LFSR_W-2:0], rb};
         if (c != SYNC_BITS) begin
            c = c + SYNC_W'(1);
         end
      end
      return {h, c, n};
   endfunction

   // Generator next-byte paths, burst length decode and checker byte step.
   always_comb begin
      seed_step_c = prbs_step8(SEED);
      run_step_c  = prbs_step8(lfsr);
      len_c       = (burst_len == '0) ? FULL_LEN : CNT_W'(burst_len);
      accept_c    = (state == IDLE) && start;
      chk_c       = check_step8(hist, rx_cnt, check_in);
      {hist_nxt_c, rx_cnt_nxt_c, nerr_c} = chk_c;
      err_sum_c   = SUM_W'(err_cnt) + SUM_W'(nerr_c);
      err_sat_c   = err_sum_c[BYTE_W] ? '1 : err_sum_c[BYTE_W-1:0];
   end

   // Burst FSM and generator output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= SEED;
         byte_cnt   <= '0;
         len_q      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // First byte comes straight from the seed so it is valid next cycle.
                  state      <= RUN;
                  len_q      <= len_c;
                  lfsr       <= seed_step_c[STEP_W-1:BYTE_W];
                  data_out   <= seed_step_c[BYTE_W-1:0];
                  data_valid <= 1'b1;
                  busy       <= 1'b1;
                  byte_cnt   <= CNT_W'(1);
               end
            end
            RUN: begin
               if (abort) begin
                  state      <= IDLE;
                  data_valid <= 1'b0;
                  busy       <= 1'b0;
                  byte_cnt   <= '0;
               end else if (byte_cnt == len_q) begin
                  state      <= DONE;
                  data_valid <= 1'b0;
                  done       <= 1'b1;
                  byte_cnt   <= '0;
               end else begin
                  lfsr       <= run_step_c[STEP_W-1:BYTE_W];
                  data_out   <= run_step_c[BYTE_W-1:0];
                  byte_cnt   <= byte_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               data_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   // Loopback checker: cleared by reset or an accepted start, otherwise runs on check_valid.
   always_ff @(posedge clk) begin
      if (rst || accept_c) begin
         hist    <= '0;
         rx_cnt  <= '0;
         err_cnt <= '0;
         synced  <= 1'b0;
      end else if (check_valid) begin
         hist    <= hist_nxt_c;
         rx_cnt  <= rx_cnt_nxt_c;
         err_cnt <= err_sat_c;
         synced  <= (rx_cnt_nxt_c == SYNC_BITS);
      end
   end

endmodule
